dummy_bitrev: RTL and testbench
===============================

Name: dummy_bitrev

Overview:
- Bit-reversal block: drives its output word as the mirror image of its input word, so output bit i equals input bit (WIDTH-1-i).
- Primary path is purely combinational and 4-state exact (0/1/X/Z copied unchanged); the word comparator downstream uses case-inequality.
- Also provides a registered copy of the reversed word plus unknown-bit monitoring, for use in clocked datapaths.

Parameters:
- WIDTH, 8, data word width in bits; legal values 2..64.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- d  input  WIDTH  input word.
- o  output  WIDTH  combinational bit-reversed word: o[i] = d[WIDTH-1-i].
- q  output  WIDTH  registered bit-reversed word.
- x_flag  output  1  registered; 1 when the sampled d contained any X or Z bit.
- x_count  output  16  registered count of clock cycles in which d contained X/Z (present only with BITREV_XCOUNT_EN).

Behaviour:
- One clock, clk; reset is synchronous and active-low (rst_n); all registered outputs are updated only on the rising edge of clk.
- o:
  - Continuous assignment, zero latency, no clock or reset dependence.
  - Every bit, including X and Z, is reproduced at the mirrored position with no resolution or masking.
  - Must settle within the same simulation time step as a change on d, so it is stable well under 1 ns after d changes.
- o is a pure bit permutation: no arithmetic, no inversion, no sign handling.
- Palindromic inputs (e.g. 8'hA5, 8'h81, 8'hFF, 8'h00) produce o == d.
- q:
  - On rising clk with rst_n==0: q <= 0.
  - Otherwise: q <= reverse(d). One-cycle latency relative to d.
  - X/Z bits in d propagate into q at the mirrored position; no sanitising.
- x_flag:
  - On reset: 0.
  - Otherwise: x_flag <= 1 if any bit of d is X or Z at the sampling edge, else 0.
  - Detection uses case-equality reduction, so the flag itself is never X.
- Reset asserted mid-stream: q and x_flag go to 0 on the next rising edge regardless of d.
- o is unaffected by reset at all times.
- No handshake; d is accepted every cycle.

Optional Feature:
- Macro: BITREV_XCOUNT_EN.
- When defined:
  - x_count port exists.
  - Reset value 0.
  - Increments by 1 on each rising edge where rst_n==1 and d contains X/Z.
  - Saturates at 16'hFFFF and never wraps.
- When undefined:
  - x_count port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- d=8'b0000_0001 -> o=8'b1000_0000 immediately; after next clk edge with rst_n=1, q=8'h80 and x_flag=0.
- d=8'h0F, then 8'h3C, then 8'hA5 -> o=8'hF0, 8'h3C, 8'hA5 respectively, each checked 1 ns after the change (case-equality).
- d=8'b0000_0x10 -> o=8'b010x_0000 exactly; next edge: q=8'b010x_0000 and x_flag=1; with BITREV_XCOUNT_EN, x_count increments from 0 to 1.
- Hold rst_n=0 for 2 edges while d=8'hFF -> q=8'h00, x_flag=0, x_count=0, while o=8'hFF throughout; release rst_n -> q=8'hFF on the next edge.
- Random 0/1/X stimulus (per bit ~37.5% 1, ~50% 0, ~12.5% X), 20000 samples at 1 ns spacing -> o equals the mirrored d on every sample with case-equality.
- With BITREV_XCOUNT_EN: force 65540 consecutive X-containing cycles -> x_count stops at 16'hFFFF.

Source files
------------

// File: rtl/dummy_bitrev.sv
// dummy_bitrev: mirrors the input word bit for bit.
// o is a purely combinational, 4-state exact reversal of d. q and x_flag are
// registered copies with a synchronous active-low reset.
// Optional macro BITREV_XCOUNT_EN adds x_count, a saturating 16-bit count of
// the cycles in which d carried an X or Z bit.
module dummy_bitrev #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
`ifdef BITREV_XCOUNT_EN
    output logic [15:0]      x_count,
`endif
    output logic [WIDTH-1:0] q,
    output logic             x_flag
);

    logic [WIDTH-1:0] rev;
    logic             has_x;

    // Plain wire permutation so X and Z pass through untouched.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev[i] = d[WIDTH-1-i];
    end

    assign o = rev;

    // Any X/Z bit poisons the XOR reduction; === keeps the result 2-state.
    assign has_x = ((^d) === 1'bx);

    // Registered reversed word and unknown-bit flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q      <= '0;
            x_flag <= 1'b0;
        end else begin
            q      <= rev;
            x_flag <= has_x;
        end
    end

`ifdef BITREV_XCOUNT_EN
    // Saturating count of cycles where d contained X/Z.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_count <= 16'h0000;
        end else if (has_x && (x_count != 16'hFFFF)) begin
            x_count <= x_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_dummy_bitrev.sv
// Self-checking bench for dummy_bitrev: a driver pushes the expected
// registered response into a queue, and a monitor pops it after each edge.
module tb_dummy_bitrev;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic         flag;
        logic [15:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] o;
    logic [W-1:0] q;
    logic         x_flag;
    logic [15:0]  x_count;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [15:0] model_cnt = 16'h0000;

    always #5 clk = ~clk;

    dummy_bitrev #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .o      (o),
`ifdef BITREV_XCOUNT_EN
        .x_count(x_count),
`endif
        .q      (q),
        .x_flag (x_flag)
    );

`ifndef BITREV_XCOUNT_EN
    assign x_count = 16'h0000;
`endif

    function automatic logic [W-1:0] mirror(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = {<<{v}};
        return r;
    endfunction

    task automatic check_o(input string name);
        logic [W-1:0] e;
        e = mirror(d);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s: o=%b expected %b (d=%b)", name, o, e, d);
        end
    endtask

    // Drive one cycle of stimulus just after an edge, check o, and queue the
    // registered response expected after the next edge.
    task automatic drive(input logic [W-1:0] dv, input logic rn, input bit chk_o);
        exp_t e;
        @(posedge clk);
        #2;
        d     = dv;
        rst_n = rn;
        #1;
        if (chk_o) check_o("o_drive");
        if (!rn) begin
            model_cnt = 16'h0000;
            e.q       = '0;
            e.flag    = 1'b0;
        end else begin
            e.q    = mirror(dv);
            e.flag = $isunknown(dv);
            if (e.flag && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h0001;
        end
        e.cnt = model_cnt;
        sb.push_back(e);
    endtask

    // Monitor: compare registered outputs 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== e.q) begin
                    errors++;
                    $display("FAIL q: got %b expected %b", q, e.q);
                end
                checks++;
                if (x_flag !== e.flag) begin
                    errors++;
                    $display("FAIL x_flag: got %b expected %b", x_flag, e.flag);
                end
`ifdef BITREV_XCOUNT_EN
                checks++;
                if (x_count !== e.cnt) begin
                    errors++;
                    $display("FAIL x_count: got %h expected %h", x_count, e.cnt);
                end
`endif
            end
        end
    end

    task automatic check_lit(input string name, input logic [W-1:0] exp_o);
        checks++;
        if (o !== exp_o) begin
            errors++;
            $display("FAIL %s: o=%b expected %b", name, o, exp_o);
        end
    endtask

    initial begin
        logic [W-1:0] dv;
        int r;

        repeat (2) @(posedge clk);
        // Reset state and basic mirroring.
        drive(8'h5A, 1'b0, 1'b1);
        drive(8'b0000_0001, 1'b1, 1'b1);
        check_lit("o_01", 8'b1000_0000);
        drive(8'h0F, 1'b1, 1'b1);
        check_lit("o_0F", 8'hF0);
        drive(8'h3C, 1'b1, 1'b1);
        check_lit("o_3C", 8'h3C);
        drive(8'hA5, 1'b1, 1'b1);
        check_lit("o_A5", 8'hA5);
        drive(8'h81, 1'b1, 1'b1);
        check_lit("o_81", 8'h81);
        drive(8'hC4, 1'b1, 1'b1);
        check_lit("o_C4", 8'h23);
        drive(8'b0000_0x10, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);
        // Mid-stream reset with all-ones input; o must ignore reset.
        drive(8'hFF, 1'b0, 1'b1);
        drive(8'hFF, 1'b0, 1'b1);
        check_lit("o_FF_rst", 8'hFF);
        drive(8'hFF, 1'b1, 1'b1);
        drive(8'h12, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            drive(W'($urandom), (($urandom_range(0, 9)) != 0), 1'b1);
        end

        // Hold reset so the registered path expects zeros, then hammer o with
        // 0/1/X stimulus at 1 ns spacing.
        drive(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20000; i++) begin
            for (int b = 0; b < W; b++) begin
                r = $urandom_range(0, 7);
                if (r <= 2)      dv[b] = 1'b1;
                else if (r <= 6) dv[b] = 1'b0;
                else             dv[b] = 1'bx;
            end
            d = dv;
            #1;
            check_o("o_rand");
        end

        drive(8'h00, 1'b0, 1'b1);
        drive(8'h96, 1'b1, 1'b1);

`ifdef BITREV_XCOUNT_EN
        // Saturation: more X cycles than the counter can hold.
        for (int i = 0; i < 65540; i++) begin
            drive(8'b1x00_0000, 1'b1, 1'b0);
        end
        drive(8'h01, 1'b1, 1'b1);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
